// File: rtl/tile_anim_ctrl.sv
// Frame-synchronous scroll/flash controller for the tile sprite renderer.
// Commands are latched at any time but only applied on frame_tick, so configuration never changes mid-frame.
module tile_anim_ctrl #(
    parameter int FRAME_DIV    = 4,
    parameter int TILE_W       = 32,
    parameter int TILE_H       = 15,
    parameter int FLASH_FRAMES = 8,
    parameter int FLASH_COUNT  = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_frame_tick,
    input  logic                      i_start,
    input  logic                      i_stop,
    input  logic                      i_pause,
    input  logic                      i_flash_req,
    input  logic                      i_dir,
    output logic [$clog2(TILE_W)-1:0] o_off_x,
    output logic [$clog2(TILE_H)-1:0] o_off_y,
    output logic                      o_pal_sel,
    output logic                      o_flashing,
    output logic                      o_busy
);
    localparam int XW  = $clog2(TILE_W);
    localparam int YW  = $clog2(TILE_H);
    localparam int FW  = $clog2(FRAME_DIV + 1);
    localparam int FFW = $clog2(FLASH_FRAMES + 1);
    localparam int TW  = $clog2(2 * FLASH_COUNT + 1);

    localparam logic [XW-1:0]  X_MAX  = XW'(TILE_W - 1);
    localparam logic [YW-1:0]  Y_MAX  = YW'(TILE_H - 1);
    localparam logic [FW-1:0]  F_MAX  = FW'(FRAME_DIV - 1);
    localparam logic [FFW-1:0] FF_MAX = FFW'(FLASH_FRAMES - 1);
    localparam logic [TW-1:0]  T_LAST = TW'(2 * FLASH_COUNT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_FLASH} state_t;

    state_t          r_state, r_saved, w_state, w_saved;
    logic [XW-1:0]   r_off_x, w_off_x;
    logic [YW-1:0]   r_off_y, w_off_y;
    logic [FW-1:0]   r_fcnt_run, w_fcnt_run;
    logic [FFW-1:0]  r_fcnt, w_fcnt;
    logic [TW-1:0]   r_toggle, w_toggle;
    logic            r_pal, w_pal;
    logic            r_pend_start, w_pend_start;
    logic            r_pend_flash, w_pend_flash;
    logic            r_flashing, r_busy;
    logic            w_flashing, w_busy;

    always_comb begin
        w_state      = r_state;
        w_saved      = r_saved;
        w_off_x      = r_off_x;
        w_off_y      = r_off_y;
        w_fcnt_run   = r_fcnt_run;
        w_fcnt       = r_fcnt;
        w_toggle     = r_toggle;
        w_pal        = r_pal;
        w_pend_start = r_pend_start;
        w_pend_flash = r_pend_flash;

        if (i_frame_tick) begin
            // A pending flash pre-empts everything outside FLASH; the current state is saved for return.
            if (r_state != S_FLASH && r_pend_flash) begin
                w_saved      = r_state;
                w_state      = S_FLASH;
                w_pal        = 1'b1;
                w_toggle     = TW'(1);
                w_fcnt       = '0;
                w_pend_flash = 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (r_pend_start) begin
                        w_state      = S_RUN;
                        w_fcnt_run   = '0;
                        w_pend_start = 1'b0;
                    end
                    S_RUN: begin
                        w_pend_start = 1'b0;
                        if (i_pause) begin
                            w_state = S_PAUSED;
                        end else if (r_fcnt_run == F_MAX) begin
                            w_fcnt_run = '0;
                            // TILE_H is not a power of two, so wraps are explicit compares.
                            if (!i_dir) begin
                                if (r_off_y == Y_MAX) begin
                                    w_off_y = '0;
                                    w_off_x = (r_off_x == X_MAX) ? '0 : r_off_x + 1'b1;
                                end else begin
                                    w_off_y = r_off_y + 1'b1;
                                end
                            end else begin
                                if (r_off_y == '0) begin
                                    w_off_y = Y_MAX;
                                    w_off_x = (r_off_x == '0) ? X_MAX : r_off_x - 1'b1;
                                end else begin
                                    w_off_y = r_off_y - 1'b1;
                                end
                            end
                        end else begin
                            w_fcnt_run = r_fcnt_run + 1'b1;
                        end
                    end
                    S_PAUSED: begin
                        w_pend_start = 1'b0;
                        if (!i_pause) w_state = S_RUN;
                    end
                    default: begin
                        if (r_fcnt == FF_MAX) begin
                            w_fcnt = '0;
                            if (r_toggle == T_LAST) begin
                                w_pal   = 1'b0;
                                w_state = r_saved;
                            end else begin
                                w_toggle = r_toggle + 1'b1;
                                w_pal    = ~r_pal;
                            end
                        end else begin
                            w_fcnt = r_fcnt + 1'b1;
                        end
                    end
                endcase
            end
        end

        if (i_start) w_pend_start = 1'b1;
        if (i_flash_req && r_state != S_FLASH) w_pend_flash = 1'b1;

        if (i_stop) begin
            w_state      = S_IDLE;
            w_saved      = S_IDLE;
            w_off_x      = '0;
            w_off_y      = '0;
            w_fcnt_run   = '0;
            w_fcnt       = '0;
            w_toggle     = '0;
            w_pal        = 1'b0;
            w_pend_start = 1'b0;
            w_pend_flash = 1'b0;
        end

        w_flashing = (w_state == S_FLASH);
        w_busy     = (w_state != S_IDLE) | w_pend_start | w_pend_flash;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_saved      <= S_IDLE;
            r_off_x      <= '0;
            r_off_y      <= '0;
            r_fcnt_run   <= '0;
            r_fcnt       <= '0;
            r_toggle     <= '0;
            r_pal        <= 1'b0;
            r_pend_start <= 1'b0;
            r_pend_flash <= 1'b0;
            r_flashing   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_saved      <= w_saved;
            r_off_x      <= w_off_x;
            r_off_y      <= w_off_y;
            r_fcnt_run   <= w_fcnt_run;
            r_fcnt       <= w_fcnt;
            r_toggle     <= w_toggle;
            r_pal        <= w_pal;
            r_pend_start <= w_pend_start;
            r_pend_flash <= w_pend_flash;
            r_flashing   <= w_flashing;
            r_busy       <= w_busy;
        end
    end

    assign o_off_x    = r_off_x;
    assign o_off_y    = r_off_y;
    assign o_pal_sel  = r_pal;
    assign o_flashing = r_flashing;
    assign o_busy     = r_busy;
endmodule

// File: doc/tile_anim_ctrl.md
Name: tile_anim_ctrl

Overview:
Frame-synchronous controller that configures the tile sprite renderer.
- Generates the tile scroll offsets (off_x, off_y), which the renderer adds to Q_X/Q_Y before its modulo lookup.
- Generates a palette select that flashes the tile colours on a game event.
- Accepts asynchronous-in-frame command pulses and applies them only on the VGA frame_tick, so the renderer never changes configuration mid-frame.

Parameters:
FRAME_DIV, 4, frame_ticks per scroll step in RUN (>=1)
TILE_W, 32, tile width in pixels; off_x wraps modulo TILE_W
TILE_H, 15, tile height in pixels; off_y wraps modulo TILE_H
FLASH_FRAMES, 8, frame_ticks between palette toggles in FLASH (>=1)
FLASH_COUNT, 3, number of on/off flash cycles per flash request (>=1)

Ports:
clk  in  1  pixel/system clock
rst_n  in  1  synchronous active-low reset
frame_tick  in  1  one-cycle pulse at start of vertical blank, from VGA controller
start  in  1  pulse: begin scrolling
stop  in  1  pulse: halt and clear offsets
pause  in  1  level: freeze scrolling while high (sampled on frame_tick)
flash_req  in  1  pulse: request palette flash
dir  in  1  scroll direction, 0 = +1 per step, 1 = -1 per step (sampled on step tick)
off_x  out  $clog2(TILE_W)  horizontal tile offset
off_y  out  $clog2(TILE_H)  vertical tile offset
pal_sel  out  1  0 = normal palette, 1 = flash palette
flashing  out  1  high while in FLASH
busy  out  1  high when state != IDLE or any command pending

Behaviour:
- Reset: the clock edge with rst_n=0 gives state IDLE, off_x=0, off_y=0, pal_sel=0, flashing=0, busy=0. All counters and pending flags are cleared. Reset wins over every other input, including mid-FLASH.
- States: IDLE, RUN, PAUSED, FLASH. All outputs are registered.
- Command latching: a start or flash_req pulse sets a pending flag on the following edge. Flags hold until consumed on a frame_tick or cleared by stop/reset. busy rises the cycle after the pulse.
- stop: takes effect on the next clock edge, not frame-synced. Gives IDLE, off_x=0, off_y=0, pal_sel=0, flashing=0, pending flags cleared.
- Priority when events coincide: reset > stop > flash > pause > start.
- Nothing changes in state or outputs except on cycles with frame_tick=1, apart from stop, reset and pending-flag setting.
- On frame_tick, by state:
  - IDLE: pending flash -> FLASH (saved state IDLE). Else pending start -> RUN with frame_cnt=0. No step on the entry tick.
  - RUN: pending flash -> FLASH (saved RUN). Else pause=1 -> PAUSED. Else if frame_cnt==FRAME_DIV-1, then frame_cnt=0 and take a scroll step; otherwise frame_cnt++. start in RUN is consumed and ignored.
  - PAUSED: pending flash -> FLASH (saved PAUSED). Else pause=0 -> RUN; frame_cnt is preserved, not cleared.
  - FLASH: on entry pal_sel=1, toggle_cnt=1, fcnt=0. Each subsequent tick increments fcnt. When fcnt==FLASH_FRAMES-1, pal_sel toggles, toggle_cnt++ and fcnt=0. When toggle_cnt reaches 2*FLASH_COUNT, pal_sel=0 and the block returns to the saved state on that tick. Exit occurs FLASH_FRAMES*(2*FLASH_COUNT-1) ticks after entry.
  - FLASH: offsets and frame_cnt are frozen. pause is ignored. flash_req is not latched. start is latched and served after return.
- Scroll step, dir=0: off_y = (off_y==TILE_H-1) ? 0 : off_y+1. When off_y wraps 14->0, off_x = (off_x+1) mod TILE_W.
- Scroll step, dir=1: off_y = (off_y==0) ? TILE_H-1 : off_y-1. When off_y wraps 0->14, off_x = (off_x-1) mod TILE_W.
- Wrap compares are explicit, with no reliance on power-of-two overflow, because TILE_H is not a power of two.
- flashing = (state==FLASH).
- busy = (state!=IDLE) | pending_start | pending_flash.

Test Plan:
1. Reset: hold rst_n=0 for 2 clocks while pulsing start and flash_req -> off_x=0, off_y=0, pal_sel=0, flashing=0, busy=0. After release, no state change on the next frame_tick.
2. Scroll, defaults, dir=0: start pulse mid-frame -> busy=1 next cycle, offsets unchanged until ticks. Entry tick + 4 ticks -> off_y=1. Entry + 60 ticks -> off_y=0, off_x=1. Entry + 1920 ticks -> off_x=0, off_y=0.
3. Reverse wrap: dir=1 from reset, start, entry + 4 ticks -> off_y=14, off_x=31.
4. Flash in RUN at off_y=3: flash_req -> at the next tick pal_sel=1 and flashing=1. pal_sel toggles every 8 ticks: 0,1,0,1,0. Sixth toggle at entry + 40 ticks -> flashing=0, pal_sel=0, RUN resumes from off_y=3 with the preserved frame_cnt.
5. Pause: pause=1 for 10 ticks in RUN with frame_cnt=2 -> offsets frozen, state PAUSED. Release -> RUN at the next tick, next step 2 ticks later. Also flash during PAUSED -> returns to PAUSED.
6. Coincidence: stop and flash_req in the same cycle mid-FLASH -> IDLE, offsets 0, pal_sel=0, busy=0 next cycle, no flash on later ticks. Separately, reset asserted mid-FLASH -> identical to scenario 1.
